alu_cmd_issue: RTL and testbench

Command front-end for `alu_8bit_top`. Accepts ALU commands (operands, opcode, carry-in) over a valid/ready stream and buffers them in a small FIFO. Issues them one at a time to the ALU, waits out the ALU's registered latency, and returns each `Result` on a valid/ready response stream. It is the stage directly upstream of the ALU and also collects the ALU's output.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_cmd_fifo.sv | 59 +++++
 rtl/alu_cmd_issue.sv | 136 +++++++++++++
 tb/tb_alu_cmd_issue.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, command payload and the issue FSM states.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOT = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_SHR = 3'b111;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        logic       cin;
    } alu_cmd_t;

    localparam int unsigned ALU_CMD_W = $bits(alu_cmd_t);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } issue_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap modulo DEPTH, level counts 0..DEPTH.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  alu_cmd_t                wdata,
    input  logic                    pop,
    output alu_cmd_t                rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    alu_cmd_t           mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   cnt_q, cnt_d;
    logic               do_push, do_pop;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        cnt_d = cnt_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (cnt_q == LVL_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign level = cnt_q;

endmodule

// File: rtl/alu_cmd_issue.sv
// Command front-end for alu_8bit_top: buffers commands, issues one at a time, returns results.
// Define ALU_CMD_ZERO_FLAG_EN to add rsp_zero, registered together with rsp_data.
module alu_cmd_issue
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [7:0]              cmd_a,
    input  logic [7:0]              cmd_b,
    input  logic [2:0]              cmd_sel,
    input  logic                    cmd_cin,
    output logic [7:0]              alu_a,
    output logic [7:0]              alu_b,
    output logic [2:0]              alu_sel,
    output logic                    alu_cin,
    input  logic [7:0]              alu_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [7:0]              rsp_data,
`ifdef ALU_CMD_ZERO_FLAG_EN
    output logic                    rsp_zero,
`endif
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    issue_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    alu_cmd_t           issued_q, issued_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [7:0]         rsp_data_q, rsp_data_d;
`ifdef ALU_CMD_ZERO_FLAG_EN
    logic               rsp_zero_q, rsp_zero_d;
`endif

    alu_cmd_t           fifo_wdata, fifo_rdata;
    logic               fifo_full, fifo_empty, fifo_pop;

    // Ready depends only on full: a same-cycle pop never frees a slot for a push.
    assign cmd_ready  = !fifo_full && !rst;
    assign fifo_wdata = '{a: cmd_a, b: cmd_b, sel: cmd_sel, cin: cmd_cin};

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        issued_d    = issued_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
`ifdef ALU_CMD_ZERO_FLAG_EN
        rsp_zero_d  = rsp_zero_q;
`endif
        fifo_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                fifo_pop = 1'b1;
                issued_d = fifo_rdata;
                cnt_d    = CNT_W'(ALU_LAT);
                state_d  = ST_WAIT;
            end
            // Counter runs ALU_LAT..0, so WAIT spans ALU_LAT+1 cycles.
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = alu_result;
`ifdef ALU_CMD_ZERO_FLAG_EN
                    rsp_zero_d  = (alu_result == 8'h00);
`endif
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            issued_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef ALU_CMD_ZERO_FLAG_EN
            rsp_zero_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            issued_q    <= issued_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef ALU_CMD_ZERO_FLAG_EN
            rsp_zero_q  <= rsp_zero_d;
`endif
        end
    end

    assign alu_a     = issued_q.a;
    assign alu_b     = issued_q.b;
    assign alu_sel   = issued_q.sel;
    assign alu_cin   = issued_q.cin;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
`ifdef ALU_CMD_ZERO_FLAG_EN
    assign rsp_zero  = rsp_zero_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue with a one-stage ALU stub; responses are scored against a queue of
// results computed from the opcode rules at the moment each command is accepted.
module tb_alu_cmd_issue;
    import alu_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ALU_LAT = 1;
    localparam int unsigned LVL_W   = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [7:0]       cmd_a = '0;
    logic [7:0]       cmd_b = '0;
    logic [2:0]       cmd_sel = '0;
    logic             cmd_cin = 1'b0;
    logic [7:0]       alu_a, alu_b;
    logic [2:0]       alu_sel;
    logic             alu_cin;
    logic [7:0]       alu_result;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [7:0]       rsp_data;
    logic [LVL_W-1:0] level;
`ifdef ALU_CMD_ZERO_FLAG_EN
    logic             rsp_zero;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       done = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_issue #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_sel    (cmd_sel),
        .cmd_cin    (cmd_cin),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
`ifdef ALU_CMD_ZERO_FLAG_EN
        .rsp_zero   (rsp_zero),
`endif
        .level      (level)
    );

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] sel, input logic cin);
        case (sel)
            ALU_ADD: return 8'(a + b + 8'(cin));
            ALU_SUB: return 8'(a - b - 8'(cin));
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_NOT: return ~a;
            ALU_SHL: return {a[6:0], 1'b0};
            default: return {1'b0, a[7:1]};
        endcase
    endfunction

    // ALU stand-in with one register stage
    logic [7:0] alu_res_q = '0;
    always_ff @(posedge clk) alu_res_q <= alu_model(alu_a, alu_b, alu_sel, alu_cin);
    assign alu_result = alu_res_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard and hold-stability monitor, sampled mid-cycle
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
`ifdef ALU_CMD_ZERO_FLAG_EN
    logic       prev_zero = 1'b0;
`endif
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check_eq("hold_valid", 32'(rsp_valid), 32'd1);
                check_eq("hold_data", 32'(rsp_data), 32'(prev_data));
`ifdef ALU_CMD_ZERO_FLAG_EN
                check_eq("hold_zero", 32'(rsp_zero), 32'(prev_zero));
`endif
            end
            if (cmd_valid && cmd_ready)
                exp_q.push_back(alu_model(cmd_a, cmd_b, cmd_sel, cmd_cin));
            if (rsp_valid && rsp_ready) begin
                check_eq("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("rsp_data", 32'(rsp_data), 32'(e));
`ifdef ALU_CMD_ZERO_FLAG_EN
                    check_eq("rsp_zero", 32'(rsp_zero), 32'(e == 8'h00));
`endif
                end
                got_q.push_back(rsp_data);
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_data = rsp_data;
`ifdef ALU_CMD_ZERO_FLAG_EN
            prev_zero = rsp_zero;
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                        input logic cin);
        logic ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        cmd_a     = a;
        cmd_b     = b;
        cmd_cin   = cin;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        cmd_valid = 1'b0;
        if (!ok) check_eq("push_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 100);
        check_eq("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    initial begin
        int         n;
        int         acc;
        int         stale;
        logic [7:0] d, a;
        logic [2:0] s;
        logic [7:0] t4_exp[3];

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_alu", 32'({alu_a, alu_b, alu_sel, alu_cin}), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", 32'(cmd_ready), 32'd1);
        tick();

        // 1: single ADD and push-to-valid latency
        push(ALU_ADD, 8'd10, 8'd5, 1'b0);
        wait_rsp(n);
        check_eq("t1_latency", 32'(n), 32'(ALU_LAT + 4));
        check_eq("t1_data", 32'(rsp_data), 32'd15);
        rsp_ready = 1'b1;
        drain(50);

        // 2: back-to-back ordering with wrap
        got_q.delete();
        push(ALU_ADD, 8'd200, 8'd100, 1'b0);
        push(ALU_SUB, 8'd50, 8'd20, 1'b0);
        push(ALU_SUB, 8'd20, 8'd50, 1'b0);
        drain(100);
        check_eq("t2_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check_eq("t2_r0", 32'(got_q[0]), 32'd44);
            check_eq("t2_r1", 32'(got_q[1]), 32'd30);
            check_eq("t2_r2", 32'(got_q[2]), 32'd226);
        end

        // 3: back-pressure fills FIFO; DEPTH+1 accepted
        got_q.delete();
        rsp_ready = 1'b0;
        acc       = 0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cmd_sel = 3'($urandom_range(0, 7));
            cmd_a   = 8'($urandom);
            cmd_b   = 8'($urandom);
            cmd_cin = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (cmd_ready) acc++;
            tick();
        end
        cmd_valid = 1'b0;
        #1;
        check_eq("t3_accepted", 32'(acc), 32'(DEPTH + 1));
        check_eq("t3_ready", 32'(cmd_ready), 32'd0);
        check_eq("t3_level", 32'(level), 32'(DEPTH));
        rsp_ready = 1'b1;
        drain(200);
        check_eq("t3_drained", 32'(got_q.size()), 32'(DEPTH + 1));

        // 4: held responses stay stable and block the next issue
        got_q.delete();
        rsp_ready = 1'b0;
        push(ALU_AND, 8'hAA, 8'h0F, 1'b0);
        push(ALU_NOT, 8'h0F, 8'h00, 1'b0);
        push(ALU_SHL, 8'h91, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            wait_rsp(n);
            d = rsp_data;
            a = alu_a;
            s = alu_sel;
            for (int j = 0; j < 3; j++) begin
                tick();
                check_eq("t4_hold_valid", 32'(rsp_valid), 32'd1);
                check_eq("t4_hold_data", 32'(rsp_data), 32'(d));
                check_eq("t4_no_issue", 32'({alu_a, alu_sel}), 32'({a, s}));
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
        t4_exp = '{8'h0A, 8'hF0, 8'h22};
        check_eq("t4_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3)
            for (int k = 0; k < 3; k++) check_eq("t4_data", 32'(got_q[k]), 32'(t4_exp[k]));

        // 5: reset during WAIT with two queued
        rsp_ready = 1'b1;
        push(ALU_ADD, 8'd1, 8'd2, 1'b0);
        push(ALU_ADD, 8'd3, 8'd4, 1'b0);
        push(ALU_ADD, 8'd5, 8'd6, 1'b0);
        check_eq("t5_level_before", 32'(level), 32'd2);
        rst = 1'b1;
        #2;
        check_eq("t5_ready_in_rst", 32'(cmd_ready), 32'd0);
        tick();
        rst = 1'b0;
        check_eq("t5_level", 32'(level), 32'd0);
        check_eq("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("t5_alu_a", 32'(alu_a), 32'd0);
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) stale++;
            tick();
        end
        check_eq("t5_stale", 32'(stale), 32'd0);
        got_q.delete();
        push(ALU_XOR, 8'hFF, 8'h0F, 1'b0);
        drain(50);
        check_eq("t5_xor", 32'(got_q.size() == 1 ? got_q[0] : 8'h00), 32'hF0);

`ifdef ALU_CMD_ZERO_FLAG_EN
        // 6: zero flag captured and held with the data
        got_q.delete();
        push(ALU_XOR, 8'h55, 8'h55, 1'b0);
        drain(50);
        check_eq("t6_data0", 32'(rsp_data), 32'h00);
        check_eq("t6_zero1", 32'(rsp_zero), 32'd1);
        push(ALU_OR, 8'h55, 8'h0F, 1'b0);
        drain(50);
        check_eq("t6_data1", 32'(rsp_data), 32'h5F);
        check_eq("t6_zero0", 32'(rsp_zero), 32'd0);
`endif

        // Randomized traffic with random consumer stalls
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    push(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                         1'($urandom_range(0, 1)));
                end
                drain(3000);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick();
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d",
                 n_errors, n_checks);
        $fatal(1);
    end

endmodule
